// File: rtl/axis_packet_fifo.sv
// axis_packet_fifo: single-clock AXI4-Stream FIFO carrying tdata, tkeep and
// tlast, with registered fill-level, packet-count and almost-full status.
// Build option: define AXIS_PACKET_FIFO_PACKET_MODE_EN for store-and-forward
// output (a packet is released only once its tlast is buffered, or when the
// FIFO is full). Without it the FIFO is cut-through.
module axis_packet_fifo #(
   parameter int TDATA_WIDTH  = 8,
   parameter int DEPTH        = 16,
   parameter int AFULL_THRESH = DEPTH - 2,
   parameter int KEEP_WIDTH   = TDATA_WIDTH / 8
) (
   input  logic                   aclk,
   input  logic                   areset,
   input  logic [TDATA_WIDTH-1:0] s_axis_tdata,
   input  logic [KEEP_WIDTH-1:0]  s_axis_tkeep,
   input  logic                   s_axis_tlast,
   input  logic                   s_axis_tvalid,
   output logic                   s_axis_tready,
   output logic [TDATA_WIDTH-1:0] m_axis_tdata,
   output logic [KEEP_WIDTH-1:0]  m_axis_tkeep,
   output logic                   m_axis_tlast,
   output logic                   m_axis_tvalid,
   input  logic                   m_axis_tready,
   output logic [$clog2(DEPTH):0] fill_level,
   output logic [$clog2(DEPTH):0] pkt_count,
   output logic                   almost_full
);
   localparam int AW = $clog2(DEPTH);
   localparam int PW = AW + 1;
   localparam int EW = TDATA_WIDTH + KEEP_WIDTH + 1;

   typedef logic [PW-1:0] cnt_t;

   logic [EW-1:0] mem [DEPTH];
   cnt_t          wr_ptr, rd_ptr;
   cnt_t          fill_next, pkt_next;
   logic          full, empty;
   logic          wr_en, rd_en, wr_last, rd_last;

   // Wrap-bit pointer comparison: same index with different lap means full.
   assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
   assign empty = (wr_ptr == rd_ptr);

   // Ready depends only on stored pointers, never on m_axis_tready; it is
   // held low while reset is asserted.
   assign s_axis_tready = !full && !areset;

   assign wr_en   = s_axis_tvalid && s_axis_tready;
   assign rd_en   = m_axis_tvalid && m_axis_tready;
   assign wr_last = wr_en && s_axis_tlast;
   assign rd_last = rd_en && m_axis_tlast;

   // Head entry drives the read side directly; it cannot change until read.
   assign {m_axis_tdata, m_axis_tkeep, m_axis_tlast} = mem[rd_ptr[AW-1:0]];

   // Storage write on an accepted beat.
   always_ff @(posedge aclk) begin
      // NOTE: the array has no reset; stale entries are unreachable because
      // the pointers are reset, and leaving it out keeps it mappable to RAM.
      if (wr_en) begin
         mem[wr_ptr[AW-1:0]] <= {s_axis_tdata, s_axis_tkeep, s_axis_tlast};
      end
   end

   // Pointer advance on write and read accepts.
   always_ff @(posedge aclk) begin
      // NOTE: state is updated with <= so every register samples pre-edge
      // values no matter how the blocks are ordered.
      if (areset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else begin
         if (wr_en) wr_ptr <= wr_ptr + cnt_t'(1);
         if (rd_en) rd_ptr <= rd_ptr + cnt_t'(1);
      end
   end

   // Next-state of the status counters from this cycle's accepts.
   always_comb begin
      // NOTE: defaults come first so every path assigns and no latch appears.
      fill_next = fill_level;
      pkt_next  = pkt_count;
      if (wr_en && !rd_en) begin
         fill_next = fill_level + cnt_t'(1);
      end else if (!wr_en && rd_en) begin
         fill_next = fill_level - cnt_t'(1);
      end
      if (wr_last && !rd_last) begin
         pkt_next = pkt_count + cnt_t'(1);
      end else if (!wr_last && rd_last) begin
         pkt_next = pkt_count - cnt_t'(1);
      end
   end

   // Registered status outputs.
   always_ff @(posedge aclk) begin
      if (areset) begin
         fill_level  <= '0;
         pkt_count   <= '0;
         almost_full <= (AFULL_THRESH == 0);
      end else begin
         fill_level  <= fill_next;
         pkt_count   <= pkt_next;
         almost_full <= (int'(fill_next) >= AFULL_THRESH);
      end
   end

`ifdef AXIS_PACKET_FIFO_PACKET_MODE_EN
   logic draining;

   // Set once a packet has started leaving without its tlast, so an oversize
   // packet keeps streaming after full clears.
   always_ff @(posedge aclk) begin
      if (areset) begin
         draining <= 1'b0;
      end else if (rd_en) begin
         draining <= !m_axis_tlast;
      end
   end

   assign m_axis_tvalid = !empty && ((pkt_count != '0) || full || draining);
`else
   assign m_axis_tvalid = !empty;
`endif

endmodule
